contador_multi: RTL

Parametrised pop-event counter bank for the FIFO subsystem: one counter per FIFO unit, each incremented on that unit's `pop` pulse. A small state machine gates a pipelined readout port. While the system reports idle, a requester streams one channel index per cycle and receives that channel's count one cycle later with `valid`. Per-channel sticky overflow flags record counter wrap (or saturation, see Configuration).

---
 rtl/contador_multi_if.sv | 26 ++
 rtl/contador_multi.sv | 100 ++++++++++
 2 files changed

// File: rtl/contador_multi_if.sv
// Readout/pop bus for contador_multi: the requester drives pops, the idle
// indication and read requests; the counter bank returns count, valid and
// sticky overflow flags.
interface contador_multi_if #(
  parameter int unsigned FIFO_UNITS = 4,
  parameter int unsigned INDEX      = 2,
  parameter int unsigned CNT_W      = 5
);
  logic [FIFO_UNITS-1:0] pop;
  logic                  IDLE;
  logic                  req;
  logic [INDEX-1:0]      idx;
  logic [CNT_W-1:0]      cuenta;
  logic                  valid;
  logic [FIFO_UNITS-1:0] overflow;

  modport master (
    output pop, IDLE, req, idx,
    input  cuenta, valid, overflow
  );

  modport slave (
    input  pop, IDLE, req, idx,
    output cuenta, valid, overflow
  );
endinterface

// File: rtl/contador_multi.sv
// contador_multi: per-FIFO pop-event counter bank with an idle-gated,
// one-cycle-latency readout port and sticky per-channel overflow flags.
// Build option: define CONTADOR_SAT_EN to make counters saturate at their
// maximum instead of wrapping (overflow still flags the first lost pop).
module contador_multi #(
  parameter int unsigned FIFO_UNITS = 4,
  parameter int unsigned INDEX      = 2,
  parameter int unsigned CNT_W      = 5
) (
  input logic             clk,
  input logic             reset,
  contador_multi_if.slave bus
);

  typedef enum logic [1:0] {S_INIT, S_COUNT, S_READ} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt [FIFO_UNITS];
  logic [FIFO_UNITS-1:0] r_ovf;
  logic [CNT_W-1:0]      r_cuenta;
  logic                  r_valid;
  logic                  w_fire;
  logic [CNT_W-1:0]      w_rd_data;
  logic [INDEX-1:0]      w_idx;

  assign w_idx = bus.idx;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next_state;
  end

  // Next-state: INIT leaves unconditionally, COUNT/READ follow IDLE
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_INIT:  w_next_state = S_COUNT;
      S_COUNT: if (bus.IDLE)  w_next_state = S_READ;
      S_READ:  if (!bus.IDLE) w_next_state = S_COUNT;
      default: w_next_state = S_INIT;
    endcase
  end

  // Read strobe and channel mux; IDLE is qualified here so the edge that
  // drops IDLE (state still READ) does not fire a read. Out-of-range
  // indices fall through to zero.
  always_comb begin
    w_fire    = (r_state == S_READ) && bus.IDLE && bus.req;
    w_rd_data = '0;
    for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
      if (32'(w_idx) == i) w_rd_data = r_cnt[i];
    end
  end

  // Per-channel counters and sticky overflow flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_UNITS; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
        if (bus.pop[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
`ifdef CONTADOR_SAT_EN
            r_cnt[i] <= CNT_MAX;
`else
            r_cnt[i] <= '0;
`endif
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Registered readout: captures pre-increment count when a read fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cuenta <= '0;
      r_valid  <= 1'b0;
    end else if (w_fire) begin
      r_cuenta <= w_rd_data;
      r_valid  <= 1'b1;
    end else begin
      r_cuenta <= '0;
      r_valid  <= 1'b0;
    end
  end

  assign bus.cuenta   = r_cuenta;
  assign bus.valid    = r_valid;
  assign bus.overflow = r_ovf;

endmodule
